stim_check: RTL and testbench

STIM_CHECK -- requirements
Module: stim_check

---
 rtl/stim_check.sv | 167 ++++++++++++++++
 tb/tb_stim_check.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_check.sv
// Purpose: sweeps a 2-input DUT through a Gray-ordered truth table and checks each response.
// Latency: Start at cycle t gives Done at t+1+4*(SETTLE+1); each vector is held SETTLE+1 cycles.
// Backpressure: none; Start is accepted only in IDLE/DONE and ignored while Busy or in reset.
module stim_check #(
   parameter int SETTLE = 4,
   parameter int OP     = 0
) (
   input  logic       QClk,
   input  logic       RstQnn,
   input  logic       Start,
   output logic       In0,
   output logic       In1,
   input  logic       DutOut,
   output logic       Busy,
   output logic       Done,
   output logic       Pass,
   output logic [2:0] ErrCnt,
   output logic       FailValid,
   output logic [1:0] FailIdx
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            in0_q, in0_d;
   logic            in1_q, in1_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [2:0]      err_q, err_d;
   logic            fail_vld_q, fail_vld_d;
   logic [1:0]      fail_idx_q, fail_idx_d;

   logic            exp_bit;
   logic            mismatch;
   logic [1:0]      nxt_idx;

   // Reference response for the currently driven vector, selected by OP
   always_comb begin
      case (OP)
         1:       exp_bit = in0_q | in1_q;
         2:       exp_bit = in0_q ^ in1_q;
         default: exp_bit = in0_q & in1_q;
      endcase
   end

   assign mismatch = (DutOut != exp_bit);
   assign nxt_idx  = idx_q + 2'd1;

   // Next-state and next-output computation for the sweep FSM
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      in0_d      = in0_q;
      in1_d      = in1_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      fail_vld_d = fail_vld_q;
      fail_idx_d = fail_idx_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // New sweep clears all results and drives vector 0 (00)
            if (Start) begin
               state_d    = ST_SETTLE;
               idx_d      = 2'd0;
               cnt_d      = CNT_LOAD;
               in0_d      = 1'b0;
               in1_d      = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               err_d      = 3'd0;
               fail_vld_d = 1'b0;
               fail_idx_d = 2'd0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               // At most four vectors, but saturate so the count can never wrap
               if (err_q != 3'd4) begin
                  err_d = err_q + 3'd1;
               end
               if (!fail_vld_q) begin
                  fail_vld_d = 1'b1;
                  fail_idx_d = idx_q;
               end
            end
            if (idx_q != 2'd3) begin
               // Gray order 00,01,11,10: In0 = idx[1], In1 = idx[1]^idx[0]
               state_d = ST_SETTLE;
               idx_d   = nxt_idx;
               cnt_d   = CNT_LOAD;
               in0_d   = nxt_idx[1];
               in1_d   = nxt_idx[1] ^ nxt_idx[0];
            end else begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = !mismatch && (err_q == 3'd0);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous active-low reset aborts any sweep
   always_ff @(posedge QClk) begin
      if (!RstQnn) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         cnt_q      <= '0;
         in0_q      <= 1'b0;
         in1_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= 3'd0;
         fail_vld_q <= 1'b0;
         fail_idx_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         in0_q      <= in0_d;
         in1_q      <= in1_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         fail_vld_q <= fail_vld_d;
         fail_idx_q <= fail_idx_d;
      end
   end

   assign In0       = in0_q;
   assign In1       = in1_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Pass      = pass_q;
   assign ErrCnt    = err_q;
   assign FailValid = fail_vld_q;
   assign FailIdx   = fail_idx_q;

endmodule

// File: tb/tb_stim_check.sv
// Bench for stim_check: three checker instances (AND/SETTLE=4, XOR/SETTLE=1, OR/SETTLE=2)
// each driving a behavioural DUT that is ideal, stuck at 0 or stuck at 1.
// Expected sweep results are queued at Start and compared when Done rises.
module tb_stim_check;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_v [3];
   logic       in0_v   [3];
   logic       in1_v   [3];
   logic       dut_v   [3];
   logic       busy_v  [3];
   logic       done_v  [3];
   logic       pass_v  [3];
   logic       fv_v    [3];
   logic [2:0] err_v   [3];
   logic [1:0] fidx_v  [3];
   int         mode_r  [3];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic       pass;
      logic [2:0] err;
      logic       fv;
      logic [1:0] fidx;
   } exp_t;

   exp_t sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   stim_check #(.SETTLE(4), .OP(0)) u_a (
      .QClk(clk), .RstQnn(rst_n), .Start(start_v[0]), .In0(in0_v[0]), .In1(in1_v[0]),
      .DutOut(dut_v[0]), .Busy(busy_v[0]), .Done(done_v[0]), .Pass(pass_v[0]),
      .ErrCnt(err_v[0]), .FailValid(fv_v[0]), .FailIdx(fidx_v[0]));

   stim_check #(.SETTLE(1), .OP(2)) u_b (
      .QClk(clk), .RstQnn(rst_n), .Start(start_v[1]), .In0(in0_v[1]), .In1(in1_v[1]),
      .DutOut(dut_v[1]), .Busy(busy_v[1]), .Done(done_v[1]), .Pass(pass_v[1]),
      .ErrCnt(err_v[1]), .FailValid(fv_v[1]), .FailIdx(fidx_v[1]));

   stim_check #(.SETTLE(2), .OP(1)) u_c (
      .QClk(clk), .RstQnn(rst_n), .Start(start_v[2]), .In0(in0_v[2]), .In1(in1_v[2]),
      .DutOut(dut_v[2]), .Busy(busy_v[2]), .Done(done_v[2]), .Pass(pass_v[2]),
      .ErrCnt(err_v[2]), .FailValid(fv_v[2]), .FailIdx(fidx_v[2]));

   function automatic int op_of(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int set_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   function automatic logic ref_fn(input int op, input logic a, input logic b);
      case (op)
         1:       return a | b;
         2:       return a ^ b;
         default: return a & b;
      endcase
   endfunction

   // Behavioural DUTs: mode 0 ideal, 1 stuck at 0, 2 stuck at 1
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         case (mode_r[k])
            1:       dut_v[k] = 1'b0;
            2:       dut_v[k] = 1'b1;
            default: dut_v[k] = ref_fn(op_of(k), in0_v[k], in1_v[k]);
         endcase
      end
   end

   function automatic exp_t model(input int k, input int mode);
      exp_t       e;
      logic [1:0] v;
      logic       a, b, r, d;
      e.pass = 1'b0; e.err = 3'd0; e.fv = 1'b0; e.fidx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         v = i[1:0];
         a = v[1];
         b = v[1] ^ v[0];
         r = ref_fn(op_of(k), a, b);
         d = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : r;
         if (d != r) begin
            if (!e.fv) e.fidx = v;
            e.fv  = 1'b1;
            e.err = e.err + 3'd1;
         end
      end
      e.pass = (e.err == 3'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic chk_reset(input int k);
      chk("rst_in0",   32'(in0_v[k]),  0);
      chk("rst_in1",   32'(in1_v[k]),  0);
      chk("rst_busy",  32'(busy_v[k]), 0);
      chk("rst_done",  32'(done_v[k]), 0);
      chk("rst_pass",  32'(pass_v[k]), 0);
      chk("rst_err",   32'(err_v[k]),  0);
      chk("rst_fv",    32'(fv_v[k]),   0);
      chk("rst_fidx",  32'(fidx_v[k]), 0);
   endtask

   // One full sweep on instance k; optional extra Start pulse at relative cycle repulse
   task automatic run_sweep(input int k, input int mode, input int repulse);
      exp_t       e;
      int         c0, n, s, lat, idx;
      logic [1:0] v;
      bit         got_done;
      mode_r[k] = mode;
      s   = set_of(k);
      lat = 1 + 4 * (s + 1);
      @(negedge clk);
      c0 = cyc;
      start_v[k] = 1'b1;
      sb.push_back(model(k, mode));
      @(negedge clk);
      got_done = 0;
      n = cyc - c0;
      while (!got_done && n < 200) begin
         if (n == 1) begin
            chk("start_err_clr",  32'(err_v[k]),  0);
            chk("start_fv_clr",   32'(fv_v[k]),   0);
            chk("start_fidx_clr", 32'(fidx_v[k]), 0);
            chk("start_pass_clr", 32'(pass_v[k]), 0);
         end
         if (done_v[k]) begin
            got_done = 1;
         end else if (n < lat) begin
            idx = (n - 1) / (s + 1);
            v   = idx[1:0];
            chk("sweep_busy", 32'(busy_v[k]), 1);
            chk("sweep_in0",  32'(in0_v[k]),  32'(v[1]));
            chk("sweep_in1",  32'(in1_v[k]),  32'(v[1] ^ v[0]));
         end
         if (!got_done) begin
            start_v[k] = (n == repulse) ? 1'b1 : 1'b0;
            @(negedge clk);
            n = cyc - c0;
         end
      end
      start_v[k] = 1'b0;
      chk("done_seen", 32'(got_done), 1);
      if (got_done) begin
         chk("done_latency", 32'(n), 32'(lat));
         e = sb.pop_front();
         chk("res_pass", 32'(pass_v[k]), 32'(e.pass));
         chk("res_err",  32'(err_v[k]),  32'(e.err));
         chk("res_fv",   32'(fv_v[k]),   32'(e.fv));
         chk("res_fidx", 32'(fidx_v[k]), 32'(e.fidx));
         chk("res_busy", 32'(busy_v[k]), 0);
         @(negedge clk);
         chk("done_hold", 32'(done_v[k]), 1);
         chk("pass_hold", 32'(pass_v[k]), 32'(e.pass));
      end
   endtask

   initial begin
      exp_t e;
      int   c0, prev, pulses;
      bit   seen;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         mode_r[k]  = 0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) chk_reset(k);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) chk("idle_wait_busy", 32'(busy_v[k]), 0);

      // AND: ideal, then stuck-at-0
      run_sweep(0, 0, 0);
      run_sweep(0, 1, 0);
      // XOR with SETTLE=1: stuck-at-1, then ideal restart from DONE, then ignored re-pulse
      run_sweep(1, 2, 0);
      run_sweep(1, 0, 0);
      run_sweep(1, 0, 3);
      // OR: ideal, then stuck-at-0
      run_sweep(2, 0, 0);
      run_sweep(2, 1, 0);

      // Reset during SETTLE of vector 2 on instance A, with Start high in the reset cycle
      mode_r[0] = 0;
      @(negedge clk);
      c0 = cyc;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      while (cyc - c0 < 12) @(negedge clk);
      chk("abort_pre_in0",  32'(in0_v[0]),  1);
      chk("abort_pre_in1",  32'(in1_v[0]),  1);
      chk("abort_pre_busy", 32'(busy_v[0]), 1);
      start_v[0] = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start_v[0] = 1'b0;
      chk_reset(0);
      repeat (3) @(negedge clk);
      chk("abort_idle_busy", 32'(busy_v[0]), 0);
      chk("abort_idle_done", 32'(done_v[0]), 0);
      run_sweep(0, 0, 0);

      // Start held high: back-to-back sweeps, one-cycle Done, ErrCnt cleared each sweep
      mode_r[0] = 1;
      @(negedge clk);
      c0 = cyc;
      prev = c0;
      pulses = 0;
      start_v[0] = 1'b1;
      sb.push_back(model(0, 1));
      while (pulses < 3 && cyc - c0 < 200) begin
         @(negedge clk);
         if (done_v[0]) begin
            pulses++;
            chk("cont_period", 32'(cyc - prev), 21);
            prev = cyc;
            e = sb.pop_front();
            chk("cont_err",  32'(err_v[0]),  32'(e.err));
            chk("cont_pass", 32'(pass_v[0]), 32'(e.pass));
            sb.push_back(model(0, 1));
            @(negedge clk);
            chk("cont_done_1cyc", 32'(done_v[0]), 0);
            chk("cont_err_clr",   32'(err_v[0]),  0);
            chk("cont_busy",      32'(busy_v[0]), 1);
         end
      end
      chk("cont_pulses", 32'(pulses), 3);
      start_v[0] = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done_v[0]) seen = 1;
      end
      chk("cont_tail_done", 32'(seen), 1);
      if (seen) begin
         e = sb.pop_front();
         chk("cont_tail_err", 32'(err_v[0]), 32'(e.err));
         chk("cont_tail_fidx", 32'(fidx_v[0]), 32'(e.fidx));
      end
      chk("sb_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
